// File: rtl/spi_slave.sv
// SPI target (CPOL=0, CPHA selectable by mode) with synchronized inputs,
// a one-deep TX holding register and a one-cycle rx_valid strobe.
// Optional SPI_SLAVE_OVR_EN adds rx_ack/rx_ovr unread-data overrun reporting.
module spi_slave #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  input  logic             mode,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
`ifdef SPI_SLAVE_OVR_EN
  input  logic             rx_ack,
  output logic             rx_ovr,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   sample_edge;
  logic                   shift_edge;
  logic                   last_bit;
  logic                   cs_load;
  logic                   frame_done;
  logic                   shift_load;
  logic                   mode_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WIDTH-1:0]       tx_hold;
  logic [WIDTH-1:0]       tx_shift;
  logic [WIDTH-1:0]       rx_shift;
  logic [WIDTH-1:0]       rx_next;
  logic [WIDTH-1:0]       load_word;

  // Input synchronizers plus one extra delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  // Edge decode, bit-slot selection and shift-register load events
  always_comb begin
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    cs_s        = cs_sync[SYNC_STAGES-1];
    mosi_s      = mosi_sync[SYNC_STAGES-1];
    sclk_rise   = sclk_s & ~sclk_d;
    sclk_fall   = ~sclk_s & sclk_d;
    cs_rise     = cs_s & ~cs_d;
    cs_fall     = ~cs_s & cs_d;
    sample_edge = mode_q ? sclk_fall : sclk_rise;
    shift_edge  = mode_q ? sclk_rise : sclk_fall;
    last_bit    = (bit_cnt == CNT_W'(WIDTH - 1));
    rx_next     = {rx_shift[WIDTH-2:0], mosi_s};
    cs_load     = (state == IDLE) && cs_fall;
    frame_done  = (state == ACTIVE) && !cs_rise && sample_edge && last_bit;
    shift_load  = cs_load || frame_done;
    load_word   = tx_ready ? '0 : tx_hold;
  end

  // TX holding register; a same-cycle consume takes the old (empty) content
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold  <= '0;
      tx_ready <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_hold  <= tx_data;
      tx_ready <= 1'b0;
    end else if (shift_load) begin
      tx_ready <= 1'b1;
    end
  end

  // Frame FSM with shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      miso     <= 1'b0;
      mode_q   <= 1'b0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          miso    <= 1'b0;
          bit_cnt <= '0;
          if (cs_fall) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            rx_shift <= '0;
            // mode 0 presents the MSB before the first rising sclk
            if (!mode_q) begin
              miso     <= load_word[WIDTH-1];
              tx_shift <= {load_word[WIDTH-2:0], 1'b0};
            end else begin
              tx_shift <= load_word;
            end
          end else begin
            mode_q <= mode;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // End of select; any partial frame is dropped
            state    <= IDLE;
            busy     <= 1'b0;
            miso     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
          end else begin
            if (shift_edge) begin
              miso     <= tx_shift[WIDTH-1];
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (last_bit) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                tx_shift <= load_word;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          miso  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_OVR_EN
  logic rx_pending;

  // Unread-data flag; an ack coincident with completion counts as read first
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pending <= 1'b0;
      rx_ovr     <= 1'b0;
    end else begin
      rx_ovr <= 1'b0;
      if (frame_done) begin
        rx_pending <= 1'b1;
        if (rx_pending && !rx_ack) rx_ovr <= 1'b1;
      end else if (rx_ack) begin
        rx_pending <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: both modes, underrun, back-to-back, abort,
// reset mid-frame and (with SPI_SLAVE_OVR_EN) overrun reporting.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       mode;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
`ifdef SPI_SLAVE_OVR_EN
  logic       rx_ack;
  logic       rx_ovr;
  int         ovr_cycles = 0;
`endif

  int checks = 0;
  int errors = 0;
  int rv_cycles = 0;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .mode     (mode),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef SPI_SLAVE_OVR_EN
    .rx_ack   (rx_ack),
    .rx_ovr   (rx_ovr),
`endif
    .busy     (busy)
  );

  // clk = 10 ns; sclk half period = 50 ns (clk = 10x sclk)
  always #5 clk = ~clk;

  // Count cycles each strobe is high
  always @(posedge clk) begin
    if (rx_valid) rv_cycles <= rv_cycles + 1;
`ifdef SPI_SLAVE_OVR_EN
    if (rx_ovr) ovr_cycles <= ovr_cycles + 1;
`endif
  end

  task automatic load_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    #10;
    tx_valid = 1'b0;
  endtask

  task automatic start_cs();
    cs = 1'b0;
    #100;
  endtask

  task automatic end_cs();
    #50;
    cs = 1'b1;
    #100;
  endtask

  task automatic set_mode(input logic m);
    mode = m;
    #50;
  endtask

  // Master side: drives nbits of mo MSB first and captures miso
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (mode == 1'b0) begin
        mosi = mo[7-i];
        #50;
        sclk = 1'b1;
        mi[7-i] = miso;
        #50;
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = mo[7-i];
        #50;
        sclk = 1'b0;
        mi[7-i] = miso;
        #50;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #30;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso actual=%b expected=0", miso); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready actual=%b expected=1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data actual=%h expected=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid actual=%b expected=0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    rst = 1'b0;
    #20;
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int rv0;
    set_mode(1'b0);
    load_tx(8'h5A);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL m0_tx_ready_loaded actual=%b expected=0", tx_ready); end
    rv0 = rv_cycles;
    start_cs();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL m0_tx_ready_after_cs actual=%b expected=1", tx_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy actual=%b expected=1", busy); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL m0_first_bit actual=%b expected=0", miso); end
    spi_xfer(8'hB3, 8, mi);
    end_cs();
    checks++; if (mi !== 8'h5A) begin errors++; $display("FAIL m0_miso_byte actual=%h expected=5a", mi); end
    checks++; if (rx_data !== 8'hB3) begin errors++; $display("FAIL m0_rx_data actual=%h expected=b3", rx_data); end
    checks++; if (rv_cycles - rv0 !== 1) begin errors++; $display("FAIL m0_rx_valid_cycles actual=%0d expected=1", rv_cycles - rv0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end actual=%b expected=0", busy); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL m0_miso_idle actual=%b expected=0", miso); end
  endtask

  task automatic test_mode1();
    logic [7:0] mi;
    int rv0;
    set_mode(1'b1);
    load_tx(8'hC3);
    rv0 = rv_cycles;
    start_cs();
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL m1_miso_before_edge actual=%b expected=0", miso); end
    spi_xfer(8'h3C, 8, mi);
    end_cs();
    checks++; if (mi !== 8'hC3) begin errors++; $display("FAIL m1_miso_byte actual=%h expected=c3", mi); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL m1_rx_data actual=%h expected=3c", rx_data); end
    checks++; if (rv_cycles - rv0 !== 1) begin errors++; $display("FAIL m1_rx_valid_cycles actual=%0d expected=1", rv_cycles - rv0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1;
    logic [7:0] mi2;
    int rv0;
    set_mode(1'b0);
    rv0 = rv_cycles;
    start_cs();
    spi_xfer(8'h11, 8, mi1);
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_rx_first actual=%h expected=11", rx_data); end
    spi_xfer(8'h22, 8, mi2);
    end_cs();
    checks++; if (mi1 !== 8'h00) begin errors++; $display("FAIL b2b_underrun_1 actual=%h expected=00", mi1); end
    checks++; if (mi2 !== 8'h00) begin errors++; $display("FAIL b2b_underrun_2 actual=%h expected=00", mi2); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL b2b_rx_second actual=%h expected=22", rx_data); end
    checks++; if (rv_cycles - rv0 !== 2) begin errors++; $display("FAIL b2b_rx_valid_cycles actual=%0d expected=2", rv_cycles - rv0); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int rv0;
    set_mode(1'b0);
    rv0 = rv_cycles;
    start_cs();
    spi_xfer(8'hFF, 4, mi);
    end_cs();
    checks++; if (rv_cycles - rv0 !== 0) begin errors++; $display("FAIL abort_rx_valid actual=%0d expected=0", rv_cycles - rv0); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL abort_rx_data actual=%h expected=22", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy actual=%b expected=0", busy); end
    rv0 = rv_cycles;
    start_cs();
    spi_xfer(8'hA5, 8, mi);
    end_cs();
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL abort_next_rx actual=%h expected=a5", rx_data); end
    checks++; if (rv_cycles - rv0 !== 1) begin errors++; $display("FAIL abort_next_valid actual=%0d expected=1", rv_cycles - rv0); end
    checks++; if (mi !== 8'h00) begin errors++; $display("FAIL abort_next_miso actual=%h expected=00", mi); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    int rv0;
    set_mode(1'b0);
    start_cs();
    load_tx(8'h77);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tx_ready_pre actual=%b expected=0", tx_ready); end
    spi_xfer(8'hE0, 3, mi);
    rst = 1'b1;
    #20;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso actual=%b expected=0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy actual=%b expected=0", busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready actual=%b expected=1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data actual=%h expected=00", rx_data); end
    rst = 1'b0;
    rv0 = rv_cycles;
    spi_xfer(8'h00, 5, mi);
    end_cs();
    checks++; if (mi !== 8'h00) begin errors++; $display("FAIL rstmid_miso_rest actual=%h expected=00", mi); end
    checks++; if (rv_cycles - rv0 !== 0) begin errors++; $display("FAIL rstmid_rx_valid actual=%0d expected=0", rv_cycles - rv0); end
    rv0 = rv_cycles;
    start_cs();
    spi_xfer(8'h81, 8, mi);
    end_cs();
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL rstmid_next_rx actual=%h expected=81", rx_data); end
    checks++; if (rv_cycles - rv0 !== 1) begin errors++; $display("FAIL rstmid_next_valid actual=%0d expected=1", rv_cycles - rv0); end
  endtask

`ifdef SPI_SLAVE_OVR_EN
  task automatic ack_pulse();
    rx_ack = 1'b1;
    #10;
    rx_ack = 1'b0;
    #10;
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    int ov0;
    set_mode(1'b0);
    ack_pulse();
    ov0 = ovr_cycles;
    start_cs();
    spi_xfer(8'h01, 8, mi);
    checks++; if (ovr_cycles - ov0 !== 0) begin errors++; $display("FAIL ovr_first actual=%0d expected=0", ovr_cycles - ov0); end
    spi_xfer(8'h02, 8, mi);
    end_cs();
    checks++; if (ovr_cycles - ov0 !== 1) begin errors++; $display("FAIL ovr_second actual=%0d expected=1", ovr_cycles - ov0); end
    checks++; if (rx_data !== 8'h02) begin errors++; $display("FAIL ovr_rx_data actual=%h expected=02", rx_data); end
    ack_pulse();
    ov0 = ovr_cycles;
    start_cs();
    spi_xfer(8'h03, 8, mi);
    end_cs();
    ack_pulse();
    start_cs();
    spi_xfer(8'h04, 8, mi);
    end_cs();
    checks++; if (ovr_cycles - ov0 !== 0) begin errors++; $display("FAIL ovr_acked actual=%0d expected=0", ovr_cycles - ov0); end
  endtask
`endif

  initial begin
    cs       = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    mode     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
`ifdef SPI_SLAVE_OVR_EN
    rx_ack   = 1'b0;
`endif
    test_reset();
    test_mode0();
    test_mode1();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
`ifdef SPI_SLAVE_OVR_EN
    test_overrun();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
